// File: rtl/da_vinci_mem_responder.sv
// Memory-side responder for the DA_VINCI bus: 4-phase READ/WRITE handshake with
// programmable wait states, a small synchronous word store and a tristate DATA driver.
module da_vinci_mem_responder #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 26,
   parameter int unsigned STORE_AW    = 8,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   inout  wire  [DATA_WIDTH-1:0] DATA,
   input  logic                  READ,
   input  logic                  WRITE,
   output logic                  READY,
   output logic                  ERR
);

   typedef enum logic [1:0] {StIdle, StWait, StResp, StHold} state_e;

   localparam logic [3:0] WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  is_read_q, is_read_d;
   logic [STORE_AW-1:0]   idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] store_q [2**STORE_AW];

   logic                  enter_resp;
   logic                  resp_read;
   logic [STORE_AW-1:0]   resp_idx;
   logic [DATA_WIDTH-1:0] resp_wdata;
   logic                  store_we;
   logic                  idle_req;
   logic                  drive_en;

   // Aliasing is intentional: only the low STORE_AW address bits select a word.
   logic unused_addr_hi;
   assign unused_addr_hi = ^ADDR[ADDR_WIDTH-1:STORE_AW];

   assign idle_req = !READ && !WRITE;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_read_d  = is_read_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      enter_resp = 1'b0;
      resp_read  = is_read_q;
      resp_idx   = idx_q;
      resp_wdata = wdata_q;
      store_we   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (READ && WRITE) begin
               err_d = 1'b1;
            end else if (READ || WRITE) begin
               is_read_d = READ;
               idx_d     = ADDR[STORE_AW-1:0];
               if (WRITE) begin
                  wdata_d = DATA;
               end
               if (WAIT_STATES > 0) begin
                  state_d = StWait;
                  cnt_d   = WaitInit;
               end else begin
                  // Zero wait states: commit/fetch straight from the live bus.
                  enter_resp = 1'b1;
                  resp_read  = READ;
                  resp_idx   = ADDR[STORE_AW-1:0];
                  resp_wdata = DATA;
               end
            end
         end
         StWait: begin
            if (idle_req) begin
               state_d = StIdle;
            end else if (cnt_q == 4'd0) begin
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d = StHold;
         end
         StHold: begin
            if (idle_req) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (enter_resp) begin
         state_d = StResp;
         if (resp_read) begin
            rdata_d = store_q[resp_idx];
         end else begin
            store_we = 1'b1;
         end
      end

      ready_d = (state_d == StResp) || (state_d == StHold);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         is_read_q <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_read_q <= is_read_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   // Store survives reset; a write lands only on a RESP entry edge outside reset.
   always_ff @(posedge CLK) begin
      if (store_we && !RST) begin
         store_q[resp_idx] <= resp_wdata;
      end
   end

   // Gated by live READ so the bus frees in the same cycle the requester drops it.
   assign drive_en = ((state_q == StResp) || (state_q == StHold)) && is_read_q && READ;
   assign DATA     = drive_en ? rdata_q : {DATA_WIDTH{1'bz}};

   assign READY = ready_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_da_vinci_mem_responder.sv
// Directed bench: one responder with 2 wait states, one with none; the bench drives
// 0 onto DATA whenever it expects the responder to be released.
module tb_da_vinci_mem_responder;

   logic        clk;
   logic        rst;
   logic [25:0] addr  [2];
   logic        rd    [2];
   logic        wr    [2];
   logic        oe    [2];
   logic [31:0] wd    [2];
   logic        ready [2];
   logic        err   [2];
   wire  [31:0] bus_a;
   wire  [31:0] bus_b;

   int errors;
   int checks;

   assign bus_a = oe[0] ? wd[0] : 32'bz;
   assign bus_b = oe[1] ? wd[1] : 32'bz;

   da_vinci_mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (26),
      .STORE_AW   (8),
      .WAIT_STATES(2)
   ) u_dut_ws2 (
      .CLK  (clk),
      .RST  (rst),
      .ADDR (addr[0]),
      .DATA (bus_a),
      .READ (rd[0]),
      .WRITE(wr[0]),
      .READY(ready[0]),
      .ERR  (err[0])
   );

   da_vinci_mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (26),
      .STORE_AW   (8),
      .WAIT_STATES(0)
   ) u_dut_ws0 (
      .CLK  (clk),
      .RST  (rst),
      .ADDR (addr[1]),
      .DATA (bus_b),
      .READ (rd[1]),
      .WRITE(wr[1]),
      .READY(ready[1]),
      .ERR  (err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] bus(input int d);
      return (d == 0) ? bus_a : bus_b;
   endfunction

   // Full 4-phase transaction; lat is the number of cycles READY must stay low after sampling.
   task automatic xact(input int d, input bit is_wr, input logic [25:0] a, input logic [31:0] v,
                       input int lat);
      addr[d] = a;
      if (is_wr) begin
         wd[d] = v;
         oe[d] = 1'b1;
         wr[d] = 1'b1;
      end else begin
         oe[d] = 1'b0;
         rd[d] = 1'b1;
      end
      for (int i = 0; i < lat; i++) begin
         step();
         check("ready_early", {31'b0, ready[d]}, 32'd0);
      end
      step();
      check("ready_rise", {31'b0, ready[d]}, 32'd1);
      if (!is_wr) check("rdata", bus(d), v);
      rd[d] = 1'b0;
      wr[d] = 1'b0;
      oe[d] = 1'b1;
      wd[d] = 32'h0;
      #1;
      check("bus_release", bus(d), 32'h0);
      step();
      check("ready_hold", {31'b0, ready[d]}, 32'd1);
      step();
      check("ready_fall", {31'b0, ready[d]}, 32'd0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      for (int d = 0; d < 2; d++) begin
         addr[d] = '0;
         rd[d]   = 1'b0;
         wr[d]   = 1'b0;
         oe[d]   = 1'b1;
         wd[d]   = 32'h0;
      end
      step();
      step();
      check("rst_ready", {31'b0, ready[0]}, 32'd0);
      check("rst_err", {31'b0, err[0]}, 32'd0);
      check("rst_bus", bus_a, 32'h0);
      rst = 1'b0;
      step();

      // Basic write then read, 2 wait states.
      xact(0, 1'b1, 26'h0000005, 32'hDEADBEEF, 2);
      xact(0, 1'b0, 26'h0000005, 32'hDEADBEEF, 2);

      // Upper address bits alias.
      xact(0, 1'b1, 26'h0000103, 32'h12345678, 2);
      xact(0, 1'b0, 26'h0000003, 32'h12345678, 2);

      // Both requests high: ERR each cycle, no response, store untouched.
      addr[0] = 26'h0000005;
      wd[0]   = 32'h55555555;
      rd[0]   = 1'b1;
      wr[0]   = 1'b1;
      step();
      check("err_1", {31'b0, err[0]}, 32'd1);
      check("err_ready_1", {31'b0, ready[0]}, 32'd0);
      step();
      check("err_2", {31'b0, err[0]}, 32'd1);
      check("err_ready_2", {31'b0, ready[0]}, 32'd0);
      rd[0] = 1'b0;
      wr[0] = 1'b0;
      wd[0] = 32'h0;
      step();
      check("err_clear", {31'b0, err[0]}, 32'd0);
      xact(0, 1'b0, 26'h0000005, 32'hDEADBEEF, 2);

      // Aborted write leaves the old word in place.
      xact(0, 1'b1, 26'h0000007, 32'h0BADF00D, 2);
      addr[0] = 26'h0000007;
      wd[0]   = 32'hAAAA5555;
      wr[0]   = 1'b1;
      step();
      check("abort_wait", {31'b0, ready[0]}, 32'd0);
      wr[0] = 1'b0;
      wd[0] = 32'h0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_no_ready", {31'b0, ready[0]}, 32'd0);
      end
      xact(0, 1'b0, 26'h0000007, 32'h0BADF00D, 2);

      // Reset while waiting on a read.
      addr[0] = 26'h0000005;
      oe[0]   = 1'b0;
      rd[0]   = 1'b1;
      step();
      rst   = 1'b1;
      oe[0] = 1'b1;
      #1;
      check("rst_wait_ready", {31'b0, ready[0]}, 32'd0);
      check("rst_wait_bus", bus_a, 32'h0);
      rd[0] = 1'b0;
      step();
      rst = 1'b0;
      step();
      xact(0, 1'b0, 26'h0000005, 32'hDEADBEEF, 2);

      // Reset while the read data is on the bus releases it immediately.
      oe[0] = 1'b0;
      rd[0] = 1'b1;
      step();
      step();
      step();
      check("pre_rst_data", bus_a, 32'hDEADBEEF);
      rst   = 1'b1;
      #1;
      check("rst_resp_ready", {31'b0, ready[0]}, 32'd0);
      oe[0] = 1'b1;
      #1;
      check("rst_resp_bus", bus_a, 32'h0);
      rd[0] = 1'b0;
      step();
      rst = 1'b0;
      step();
      xact(0, 1'b0, 26'h0000005, 32'hDEADBEEF, 2);

      // Zero wait states, chained.
      xact(1, 1'b1, 26'h0000001, 32'h11111111, 0);
      xact(1, 1'b0, 26'h0000001, 32'h11111111, 0);
      xact(1, 1'b1, 26'h0000002, 32'h22222222, 0);
      xact(1, 1'b0, 26'h0000002, 32'h22222222, 0);
      xact(1, 1'b0, 26'h0000001, 32'h11111111, 0);
      check("ws0_err", {31'b0, err[1]}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
